mmp_cmd_receiver: RTL and testbench

- Upstream neighbour of the MMP command sequencer.
- Accepts the byte stream written by the Pico over an asynchronous 8-bit parallel strobe bus and synchronises it into i_CLK.
- Assembles bytes MSB-first into 24-bit MMP command words and buffers them in a FIFO.
- Presents the FIFO through the pop/data/empty interface the sequencer consumes.
- Reports full-flow-control back to the Pico and flags dropped words.

---
 rtl/mmp_pkg.sv | 27 ++
 rtl/mmp_sync_fifo.sv | 70 +++++++
 rtl/mmp_cmd_receiver.sv | 139 +++++++++++++
 tb/tb_mmp_cmd_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmp_pkg.sv
// Shared MMP command definitions: word width, opcode field and assembler states.
// Used by the receiver, the downstream sequencer and the bench.
package mmp_pkg;

   localparam int MMP_CMD_W = 24;
   localparam int OPC_MSB   = 23;
   localparam int OPC_LSB   = 19;

   localparam logic [4:0] OPC_VSYNC  = 5'b00010;
   localparam logic [4:0] OPC_PSG    = 5'b10001;
   localparam logic [4:0] OPC_OPLL   = 5'b10010;
   localparam logic [4:0] OPC_SCC    = 5'b10011;
   localparam logic [4:0] OPC_MOVOL  = 5'b11000;
   localparam logic [4:0] OPC_ROVOL  = 5'b11001;
   localparam logic [4:0] OPC_SCCSEL = 5'b11010;

   typedef enum logic [1:0] {
      ASM_B0,
      ASM_B1,
      ASM_B2
   } asm_state_t;

   function automatic logic [4:0] mmp_opcode(input logic [MMP_CMD_W-1:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/mmp_sync_fifo.sv
// Single-clock FIFO with registered read data, explicit level counter and sticky overflow.
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module mmp_sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             almost_full,
   output logic             overflow,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [LW-1:0]    level_nxt;

   always_comb begin
      do_pop    = pop && (level != '0);
      do_push   = push && ((level != LW'(DEPTH)) || do_pop);
      level_nxt = level;
      if (do_push && !do_pop) begin
         level_nxt = level + 1'b1;
      end else if (do_pop && !do_push) begin
         level_nxt = level - 1'b1;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // When full, wr_ptr == rd_ptr; the read below still sees the old head word.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         pop_data    <= '0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            pop_data <= mem[rd_ptr];
         end
         level       <= level_nxt;
         empty       <= (level_nxt == '0);
         almost_full <= (level_nxt >= LW'(DEPTH - 1));
         overflow    <= overflow | (push & ~do_push);
      end
   end

endmodule

// File: rtl/mmp_cmd_receiver.sv
// Pico strobe-bus receiver: synchronises bytes, assembles 24-bit MMP words MSB-first, buffers them.
//   state  | meaning
//   ASM_B0 | waiting for byte 0 (bits 23:16)
//   ASM_B1 | byte 0 held, waiting for byte 1 (bits 15:8)
//   ASM_B2 | bytes 0-1 held, next byte completes the word
module mmp_cmd_receiver
   import mmp_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int GAP_TIMEOUT = 17857,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic [7:0]             i_PICO_DATA,
   input  logic                   i_PICO_WR_n,
   output logic                   o_PICO_FULL,
   input  logic                   i_fifo_pop_s,
   output logic [MMP_CMD_W-1:0]   o_fifo_pop_dt,
   output logic                   o_fifo_EMPTY,
   output logic                   o_OVERFLOW,
   output logic [$clog2(DEPTH):0] o_LEVEL
);

   localparam int GW = $clog2(GAP_TIMEOUT + 1);

   logic [SYNC_STAGES-1:0]       wr_sync;
   logic [SYNC_STAGES-1:0][7:0]  data_sync;
   logic                         sync_prev;
   logic                         sync_cur;
   logic                         byte_valid;
   logic [7:0]                   sync_byte;
   logic [GW-1:0]                gap_cnt;
   logic                         gap_timeout;
   asm_state_t                   asm_state;
   asm_state_t                   asm_next;
   logic                         ld_b0;
   logic                         ld_b1;
   logic                         push_nxt;
   logic [7:0]                   byte0;
   logic [7:0]                   byte1;
   logic                         push_q;
   logic [MMP_CMD_W-1:0]         push_word;

   assign sync_cur    = wr_sync[SYNC_STAGES-1];
   assign sync_byte   = data_sync[SYNC_STAGES-1];
   assign byte_valid  = sync_prev & ~sync_cur;
   assign gap_timeout = (gap_cnt == GW'(GAP_TIMEOUT));

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         asm_state <= ASM_B0;
      end else begin
         asm_state <= asm_next;
      end
   end

   always_comb begin
      asm_next = asm_state;
      ld_b0    = 1'b0;
      ld_b1    = 1'b0;
      push_nxt = 1'b0;
      case (asm_state)
         ASM_B0: begin
            if (byte_valid) begin
               ld_b0    = 1'b1;
               asm_next = ASM_B1;
            end
         end
         ASM_B1: begin
            if (byte_valid) begin
               ld_b1    = 1'b1;
               asm_next = ASM_B2;
            end else if (gap_timeout) begin
               asm_next = ASM_B0;
            end
         end
         ASM_B2: begin
            if (byte_valid) begin
               push_nxt = 1'b1;
               asm_next = ASM_B0;
            end else if (gap_timeout) begin
               asm_next = ASM_B0;
            end
         end
         default: asm_next = ASM_B0;
      endcase
   end

   // Strobe and data share the same stage count so the byte lines up with its edge.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         wr_sync   <= '1;
         data_sync <= '0;
         sync_prev <= 1'b1;
         gap_cnt   <= '0;
         byte0     <= '0;
         byte1     <= '0;
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         wr_sync   <= {wr_sync[SYNC_STAGES-2:0], i_PICO_WR_n};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_PICO_DATA};
         sync_prev <= sync_cur;
         if (byte_valid) begin
            gap_cnt <= '0;
         end else if (!gap_timeout) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
         if (ld_b0) begin
            byte0 <= sync_byte;
         end
         if (ld_b1) begin
            byte1 <= sync_byte;
         end
         push_q <= push_nxt;
         if (push_nxt) begin
            push_word <= {byte0, byte1, sync_byte};
         end
      end
   end

   mmp_sync_fifo #(
      .WIDTH (MMP_CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_CLK       (i_CLK),
      .i_RST       (i_RST),
      .push        (push_q),
      .push_data   (push_word),
      .pop         (i_fifo_pop_s),
      .pop_data    (o_fifo_pop_dt),
      .empty       (o_fifo_EMPTY),
      .almost_full (o_PICO_FULL),
      .overflow    (o_OVERFLOW),
      .level       (o_LEVEL)
   );

endmodule

// File: tb/tb_mmp_cmd_receiver.sv
// Directed bench for mmp_cmd_receiver: latency, gap timeout, fill/overflow, full push+pop, reset.
module tb_mmp_cmd_receiver;
   import mmp_pkg::*;

   localparam int DEPTH       = 8;
   localparam int GAP_TIMEOUT = 200;
   localparam int SYNC_STAGES = 2;
   localparam int LW          = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    pico_data;
   logic          pico_wr_n;
   logic          pico_full;
   logic          pop;
   logic [23:0]   pop_dt;
   logic          empty;
   logic          ovf;
   logic [LW-1:0] level;

   int total = 0;
   int bad   = 0;
   logic [23:0] x_word;

   always #5 clk = ~clk;

   mmp_cmd_receiver #(
      .DEPTH       (DEPTH),
      .GAP_TIMEOUT (GAP_TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .i_CLK         (clk),
      .i_RST         (rst),
      .i_PICO_DATA   (pico_data),
      .i_PICO_WR_n   (pico_wr_n),
      .o_PICO_FULL   (pico_full),
      .i_fifo_pop_s  (pop),
      .o_fifo_pop_dt (pop_dt),
      .o_fifo_EMPTY  (empty),
      .o_OVERFLOW    (ovf),
      .o_LEVEL       (level)
   );

   function automatic logic [23:0] fill_word(input int i);
      logic [7:0] k;
      k = i[7:0];
      return {8'h10 + k, 8'hA0 + k, 8'h50 + k};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      pico_data = b;
      repeat (2) @(negedge clk);
      pico_wr_n = 1'b0;
      repeat (10) @(negedge clk);
      pico_wr_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_word(input logic [23:0] w);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic pop_pulse();
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (pico_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", pico_full); end
      total++; if (pop_dt !== 24'h0) begin bad++; $display("FAIL reset_dt got=%h exp=000000", pop_dt); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_word();
      send_byte(8'h88);
      send_byte(8'h07);
      @(negedge clk);
      pico_data = 8'h38;
      repeat (2) @(negedge clk);
      pico_wr_n = 1'b0;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL latency_early got=%b exp=1", empty); end
      @(negedge clk);
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL latency_empty got=%b exp=0", empty); end
      total++; if (level !== LW'(1)) begin bad++; $display("FAIL latency_level got=%0d exp=1", level); end
      repeat (6) @(negedge clk);
      pico_wr_n = 1'b1;
      repeat (3) @(negedge clk);
      pop_pulse();
      total++; if (pop_dt !== 24'h880738) begin bad++; $display("FAIL single_dt got=%h exp=880738", pop_dt); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", empty); end
      total++; if (level !== '0) begin bad++; $display("FAIL single_level got=%0d exp=0", level); end
   endtask

   task automatic test_gap_timeout();
      send_byte(8'h90);
      send_byte(8'h10);
      repeat (GAP_TIMEOUT + 50) @(negedge clk);
      send_word(24'h901030);
      repeat (5) @(negedge clk);
      total++; if (level !== LW'(1)) begin bad++; $display("FAIL gap_level got=%0d exp=1", level); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL gap_ovf got=%b exp=0", ovf); end
      pop_pulse();
      total++; if (pop_dt !== 24'h901030) begin bad++; $display("FAIL gap_dt got=%h exp=901030", pop_dt); end
      total++; if (mmp_opcode(pop_dt) !== OPC_OPLL) begin bad++; $display("FAIL gap_opcode got=%b exp=%b", mmp_opcode(pop_dt), OPC_OPLL); end
      total++; if (level !== '0) begin bad++; $display("FAIL gap_level_after got=%0d exp=0", level); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH + 1; i++) begin
         send_word(fill_word(i));
         total++;
         if (level !== LW'((i + 1 > DEPTH) ? DEPTH : i + 1)) begin
            bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, (i + 1 > DEPTH) ? DEPTH : i + 1);
         end
         total++;
         if (pico_full !== ((i + 1) >= DEPTH - 1)) begin
            bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, pico_full, ((i + 1) >= DEPTH - 1));
         end
         total++;
         if (ovf !== (i == DEPTH)) begin
            bad++; $display("FAIL fill_ovf[%0d] got=%b exp=%b", i, ovf, (i == DEPTH));
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         pop_pulse();
         total++;
         if (pop_dt !== fill_word(i)) begin
            bad++; $display("FAIL drain_dt[%0d] got=%h exp=%h", i, pop_dt, fill_word(i));
         end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
      total++; if (level !== '0) begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
   endtask

   task automatic test_full_pop_push();
      reset_pulse();
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fpp_ovf_reset got=%b exp=0", ovf); end
      for (int i = 0; i < DEPTH; i++) send_word(fill_word(i + 20));
      total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL fpp_level_full got=%0d exp=%0d", level, DEPTH); end
      x_word = 24'hC8ABCD;
      send_byte(x_word[23:16]);
      send_byte(x_word[15:8]);
      @(negedge clk);
      pico_data = x_word[7:0];
      repeat (2) @(negedge clk);
      pico_wr_n = 1'b0;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL fpp_level got=%0d exp=%0d", level, DEPTH); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", ovf); end
      total++; if (pop_dt !== fill_word(20)) begin bad++; $display("FAIL fpp_head got=%h exp=%h", pop_dt, fill_word(20)); end
      repeat (6) @(negedge clk);
      pico_wr_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         pop_pulse();
         total++;
         if (pop_dt !== ((i == DEPTH - 1) ? x_word : fill_word(21 + i))) begin
            bad++; $display("FAIL fpp_dt[%0d] got=%h exp=%h", i, pop_dt, (i == DEPTH - 1) ? x_word : fill_word(21 + i));
         end
      end
      total++; if (mmp_opcode(pop_dt) !== OPC_ROVOL) begin bad++; $display("FAIL fpp_opcode got=%b exp=%b", mmp_opcode(pop_dt), OPC_ROVOL); end
   endtask

   task automatic test_pop_empty();
      pop_pulse();
      total++; if (pop_dt !== x_word) begin bad++; $display("FAIL empty_pop_dt got=%h exp=%h", pop_dt, x_word); end
      total++; if (level !== '0) begin bad++; $display("FAIL empty_pop_level got=%0d exp=0", level); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_pop_empty got=%b exp=1", empty); end
   endtask

   task automatic test_reset_mid();
      send_word(24'h123456);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (pop_dt !== 24'h0) begin bad++; $display("FAIL rmid_dt got=%h exp=000000", pop_dt); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", empty); end
      total++; if (level !== '0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
      total++; if (pico_full !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", pico_full); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b exp=0", ovf); end
      rst = 1'b0;
      send_word(24'h110001);
      repeat (3) @(negedge clk);
      total++; if (level !== LW'(1)) begin bad++; $display("FAIL rmid_level_after got=%0d exp=1", level); end
      pop_pulse();
      total++; if (pop_dt !== 24'h110001) begin bad++; $display("FAIL rmid_word got=%h exp=110001", pop_dt); end
      total++; if (mmp_opcode(pop_dt) !== OPC_VSYNC) begin bad++; $display("FAIL rmid_opcode got=%b exp=%b", mmp_opcode(pop_dt), OPC_VSYNC); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rmid_empty_after got=%b exp=1", empty); end
   endtask

   initial begin
      rst       = 1'b1;
      pico_data = 8'h00;
      pico_wr_n = 1'b1;
      pop       = 1'b0;
      test_reset();
      test_single_word();
      test_gap_timeout();
      test_fill_overflow();
      test_full_pop_push();
      test_pop_empty();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
